spike_frame_tx: RTL and testbench

//  Parametrised framed UART transmitter for spike/sample words: buffers DATA_W-bit words
//  in a FIFO and emits fixed-length frames (SYNC, SEQ, payload MSB-first, optional XOR csum)

---
 rtl/spike_frame_tx_pkg.sv | 19 +
 rtl/spike_frame_tx_if.sv | 26 ++
 rtl/spike_frame_tx_sync_fifo.sv | 61 ++++++
 rtl/spike_frame_tx.sv | 179 +++++++++++++++++
 tb/tb_spike_frame_tx.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spike_frame_tx_pkg.sv
// Shared types and constants for the spike/sample framed UART transmitter.
package spike_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_PAYLOAD,
    ST_CSUM
  } state_e;

  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/spike_frame_tx_if.sv
// Sample-word input and uart_tx byte handshake bundle for spike_frame_tx.
interface spike_frame_tx_if #(
  parameter int unsigned DATA_W = 16
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              tx_ready;
  logic              tx_done;

  // Environment side: sampler plus uart_tx.
  modport master (
    output s_valid, s_data, tx_ready, tx_done,
    input  s_ready, tx_dv, tx_byte
  );

  // Framer side.
  modport slave (
    input  s_valid, s_data, tx_ready, tx_done,
    output s_ready, tx_dv, tx_byte
  );

endinterface

// File: rtl/spike_frame_tx_sync_fifo.sv
// Single-clock first-word-fall-through word FIFO with registered occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // A push is refused when full even if a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/spike_frame_tx.sv
// Buffers sample words and emits SYNC/SEQ/payload/CSUM frames through the uart_tx byte handshake.
module spike_frame_tx
  import spike_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned WPF        = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE,
  parameter bit          CSUM_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  spike_frame_tx_if.slave bus,
  output logic            busy,
  output logic            overflow,
  output logic [15:0]     frame_cnt
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned WW = $clog2(WPF + 1);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [BW-1:0]     byte_idx_q, byte_idx_d;
  logic [WW-1:0]     word_cnt_q, word_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        seq_q, seq_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              overflow_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  logic [7:0]        cur_byte;
  logic              load_word;
  logic              frame_end;
  logic              tx_dv_c;

  assign bus.s_ready = rst_n && !fifo_full;
  assign fifo_push   = bus.s_valid && bus.s_ready;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (bus.s_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    cur_byte = '0;
    unique case (state_q)
      ST_SYNC:    cur_byte = SYNC_BYTE;
      ST_SEQ:     cur_byte = seq_q;
      ST_PAYLOAD: cur_byte = shift_q[DATA_W-1 -: 8];
      ST_CSUM:    cur_byte = csum_q;
      default:    cur_byte = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    byte_idx_d  = byte_idx_q;
    word_cnt_d  = word_cnt_q;
    shift_d     = shift_q;
    csum_d      = csum_q;
    seq_d       = seq_q;
    frame_cnt_d = frame_cnt_q;
    load_word   = 1'b0;
    frame_end   = 1'b0;
    tx_dv_c     = 1'b0;
    fifo_pop    = 1'b0;

    if (state_q == ST_IDLE) begin
      if (en && (fifo_count >= CW'(WPF))) begin
        state_d = ST_SYNC;
        phase_d = PH_ISSUE;
        csum_d  = '0;
      end
    end else if (phase_q == PH_ISSUE) begin
      // The checksum folds in each byte as it is issued, so it is final by the CSUM state.
      if (bus.tx_ready) begin
        tx_dv_c = 1'b1;
        phase_d = PH_WAIT;
        if (state_q == ST_SEQ) begin
          csum_d = csum_q ^ seq_q;
        end else if (state_q == ST_PAYLOAD) begin
          csum_d = csum_q ^ cur_byte;
        end
      end
    end else if (bus.tx_done) begin
      phase_d = PH_ISSUE;
      unique case (state_q)
        ST_SYNC: state_d = ST_SEQ;
        ST_SEQ: begin
          state_d    = ST_PAYLOAD;
          load_word  = 1'b1;
          word_cnt_d = WW'(1);
        end
        ST_PAYLOAD: begin
          if (byte_idx_q != BW'(NB - 1)) begin
            byte_idx_d = byte_idx_q + 1'b1;
            shift_d    = shift_q << 8;
          end else if (word_cnt_q != WW'(WPF)) begin
            load_word  = 1'b1;
            word_cnt_d = word_cnt_q + 1'b1;
          end else if (CSUM_EN) begin
            state_d = ST_CSUM;
          end else begin
            frame_end = 1'b1;
          end
        end
        ST_CSUM: frame_end = 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end

    if (load_word) begin
      fifo_pop   = !fifo_empty;
      shift_d    = fifo_rdata;
      byte_idx_d = '0;
    end

    if (frame_end) begin
      state_d     = ST_IDLE;
      seq_d       = seq_q + 8'd1;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      phase_q     <= PH_ISSUE;
      byte_idx_q  <= '0;
      word_cnt_q  <= '0;
      shift_q     <= '0;
      csum_q      <= '0;
      seq_q       <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      byte_idx_q  <= byte_idx_d;
      word_cnt_q  <= word_cnt_d;
      shift_q     <= shift_d;
      csum_q      <= csum_d;
      seq_q       <= seq_d;
      frame_cnt_q <= frame_cnt_d;
      if (bus.s_valid && !bus.s_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.tx_dv   = tx_dv_c;
  assign bus.tx_byte = cur_byte;
  assign busy        = (state_q != ST_IDLE);
  assign overflow    = overflow_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_spike_frame_tx.sv
// Self-checking bench: fixed frame vectors, corner sequences and random frames against a queue model.
module tb_spike_frame_tx;

  localparam int unsigned N     = 10;
  localparam int unsigned WPF   = 2;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_a, en_b;
  logic        busy_a, busy_b, ovf_a, ovf_b;
  logic [15:0] fcnt_a, fcnt_b;

  int checks = 0;
  int errors = 0;

  spike_frame_tx_if #(.DATA_W(16)) a_if ();
  spike_frame_tx_if #(.DATA_W(16)) b_if ();

  spike_frame_tx #(
    .DATA_W(16), .WPF(WPF), .FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5), .CSUM_EN(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .bus(a_if),
    .busy(busy_a), .overflow(ovf_a), .frame_cnt(fcnt_a)
  );

  spike_frame_tx #(
    .DATA_W(16), .WPF(WPF), .FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5), .CSUM_EN(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .bus(b_if),
    .busy(busy_b), .overflow(ovf_b), .frame_cnt(fcnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // uart_tx models: ready drops for N cycles after a byte is issued, then done pulses.
  int   a_cnt = 0, b_cnt = 0;
  logic a_done = 1'b0, b_done = 1'b0, a_hold = 1'b0;
  always @(posedge clk) begin
    a_done <= (a_cnt == 1);
    if (a_cnt != 0) a_cnt <= a_cnt - 1;
    else if (a_if.tx_dv === 1'b1) a_cnt <= N;
    b_done <= (b_cnt == 1);
    if (b_cnt != 0) b_cnt <= b_cnt - 1;
    else if (b_if.tx_dv === 1'b1) b_cnt <= N;
  end
  assign a_if.tx_ready = (a_cnt == 0) && !a_hold;
  assign a_if.tx_done  = a_done;
  assign b_if.tx_ready = (b_cnt == 0);
  assign b_if.tx_done  = b_done;

  logic [7:0] a_cap[$], b_cap[$];
  always @(negedge clk) begin
    if (a_if.tx_dv === 1'b1) begin
      a_cap.push_back(a_if.tx_byte);
      chk("a_dv_needs_ready", a_if.tx_ready, 1'b1);
    end
    if (b_if.tx_dv === 1'b1) begin
      b_cap.push_back(b_if.tx_byte);
      chk("b_dv_needs_ready", b_if.tx_ready, 1'b1);
    end
  end

  // Reference model: word FIFO as a queue, frames built from the byte rules.
  logic [15:0] a_wq[$];
  logic [7:0]  a_exp[$];
  int          a_seq = 0, a_frames = 0;
  bit          a_ovf = 0;

  task automatic model_frames_a();
    while (a_wq.size() >= WPF) begin
      logic [7:0] cs;
      cs = 8'(a_seq);
      a_exp.push_back(8'hA5);
      a_exp.push_back(8'(a_seq));
      for (int w = 0; w < WPF; w++) begin
        logic [15:0] d;
        d = a_wq.pop_front();
        a_exp.push_back(d[15:8]);
        a_exp.push_back(d[7:0]);
        cs = cs ^ d[15:8] ^ d[7:0];
      end
      a_exp.push_back(cs);
      a_seq    = (a_seq + 1) % 256;
      a_frames = (a_frames + 1) % 65536;
    end
  endtask

  task automatic push_a(input logic [15:0] w, input bit exp_acc, input string name);
    a_if.s_valid = 1'b1;
    a_if.s_data  = w;
    chk(name, a_if.s_ready, exp_acc);
    @(negedge clk);
    a_if.s_valid = 1'b0;
  endtask

  task automatic mpush_a(input logic [15:0] w, input string name);
    bit acc;
    acc = (a_wq.size() < DEPTH);
    if (acc) a_wq.push_back(w);
    else a_ovf = 1'b1;
    push_a(w, acc, name);
  endtask

  task automatic check_frames_a(input string name);
    int t;
    t = 0;
    model_frames_a();
    while ((a_cap.size() < a_exp.size() || busy_a) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_timeout"}, t < 3000, 1'b1);
    chk({name, "_len"}, a_cap.size(), a_exp.size());
    for (int i = 0; i < a_exp.size() && i < a_cap.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), a_cap[i], a_exp[i]);
    chk({name, "_frame_cnt"}, fcnt_a, a_frames);
    chk({name, "_busy"}, busy_a, 1'b0);
    a_cap.delete();
    a_exp.delete();
  endtask

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [55:0] exp;
  } vec_t;
  vec_t tbl[3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stable;
    int t;
    logic [47:0] t5_exp;

    tbl[0] = '{w0: 16'h1234, w1: 16'hABCD, exp: 56'hA5_00_12_34_AB_CD_40};
    tbl[1] = '{w0: 16'h0001, w1: 16'h0002, exp: 56'hA5_01_00_01_00_02_02};
    tbl[2] = '{w0: 16'h0003, w1: 16'h0004, exp: 56'hA5_02_00_03_00_04_05};

    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    a_if.s_valid = 1'b0; a_if.s_data = '0;
    b_if.s_valid = 1'b0; b_if.s_data = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_s_ready", a_if.s_ready, 1'b0);
    chk("rst_tx_dv", a_if.tx_dv, 1'b0);
    chk("rst_tx_byte", a_if.tx_byte, 8'h00);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_overflow", ovf_a, 1'b0);
    chk("rst_frame_cnt", fcnt_a, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_ready", a_if.s_ready, 1'b1);

    // Fixed frame vectors
    en_a = 1'b1;
    for (int v = 0; v < 3; v++) begin
      push_a(tbl[v].w0, 1'b1, "tbl_acc0");
      push_a(tbl[v].w1, 1'b1, "tbl_acc1");
      t = 0;
      while ((a_cap.size() < 7 || busy_a) && t < 3000) begin
        @(negedge clk);
        t++;
      end
      chk("tbl_timeout", t < 3000, 1'b1);
      chk("tbl_len", a_cap.size(), 7);
      for (int i = 0; i < 7 && i < a_cap.size(); i++)
        chk($sformatf("tbl%0d_byte%0d", v, i), a_cap[i], tbl[v].exp[55-8*i -: 8]);
      chk("tbl_frame_cnt", fcnt_a, v + 1);
      a_cap.delete();
    end
    a_seq = 3;
    a_frames = 3;

    // Overflow with transmission disabled
    en_a = 1'b0;
    for (int k = 1; k <= 5; k++) mpush_a(16'(k * 16'h1111), $sformatf("t3_acc%0d", k));
    chk("t3_s_ready_full", a_if.s_ready, 1'b0);
    chk("t3_overflow", ovf_a, a_ovf);
    repeat (30) @(negedge clk);
    chk("t3_no_dv_while_disabled", a_cap.size(), 0);
    en_a = 1'b1;
    check_frames_a("t3");

    // uart_tx held not-ready while a frame waits in ISSUE
    a_hold = 1'b1;
    mpush_a(16'hC0DE, "t6_acc0");
    mpush_a(16'hBEEF, "t6_acc1");
    repeat (3) @(negedge clk);
    chk("t6_busy", busy_a, 1'b1);
    stable = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (a_if.tx_byte !== 8'hA5 || a_if.tx_dv !== 1'b0) stable = 1'b0;
    end
    chk("t6_byte_stable_no_dv", stable, 1'b1);
    chk("t6_no_dv", a_cap.size(), 0);
    mpush_a(16'h5A5A, "t6_acc2");
    mpush_a(16'h0F0F, "t6_acc3");
    chk("t6_full_no_pop", a_if.s_ready, 1'b0);
    a_hold = 1'b0;
    check_frames_a("t6");

    // Random frames, one or two back to back
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 2);
      en_a = 1'b0;
      for (int k = 0; k < n * WPF; k++) mpush_a(16'($urandom), "rnd_acc");
      en_a = 1'b1;
      check_frames_a("rnd");
    end

    // Reset during the second payload byte
    mpush_a(16'h7777, "t4_acc0");
    mpush_a(16'h8888, "t4_acc1");
    t = 0;
    while (a_cap.size() < 4 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("t4_reach_payload", t < 1000, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_rst_tx_dv", a_if.tx_dv, 1'b0);
    chk("t4_rst_busy", busy_a, 1'b0);
    chk("t4_rst_s_ready", a_if.s_ready, 1'b0);
    chk("t4_rst_frame_cnt", fcnt_a, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_s_ready", a_if.s_ready, 1'b1);
    chk("t4_overflow_cleared", ovf_a, 1'b0);
    chk("t4_busy", busy_a, 1'b0);
    a_cap.delete(); a_exp.delete(); a_wq.delete();
    a_seq = 0; a_frames = 0; a_ovf = 1'b0;
    mpush_a(16'h2468, "t4_acc2");
    mpush_a(16'h1357, "t4_acc3");
    check_frames_a("t4");

    // Build without checksum byte
    push_a_b: begin
      b_if.s_valid = 1'b1; b_if.s_data = 16'h00FF;
      chk("t5_acc0", b_if.s_ready, 1'b1);
      @(negedge clk);
      b_if.s_data = 16'hFF00;
      chk("t5_acc1", b_if.s_ready, 1'b1);
      @(negedge clk);
      b_if.s_valid = 1'b0;
    end
    en_b = 1'b1;
    t = 0;
    while ((b_cap.size() < 6 || busy_b) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("t5_timeout", t < 3000, 1'b1);
    repeat (30) @(negedge clk);
    t5_exp = 48'hA5_00_00_FF_FF_00;
    chk("t5_len", b_cap.size(), 6);
    for (int i = 0; i < 6 && i < b_cap.size(); i++)
      chk($sformatf("t5_byte%0d", i), b_cap[i], t5_exp[47-8*i -: 8]);
    chk("t5_frame_cnt", fcnt_b, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
